// File: rtl/fifo_stream_pkg.sv
// Shared types and widths for the FIFO stream reader slice.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready holding buffer; entry 0 is always the head.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic              do_pop;

  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    do_pop = pop && (occ_q != 2'd0);
    case ({push, do_pop})
      2'b10: begin
        // a push into a full buffer is dropped; the issue logic never allows it
        if (occ_q == 2'd0) begin
          ent0_d = push_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          ent1_d = push_data;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign head_data = ent0_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the byte FIFO through its registered read port and presents the bytes
// as a valid/ready stream, framed with m_last every PKT_LEN beats.
//
// state | meaning
// IDLE  | no pops issued; waiting for en
// RUN   | popping whenever the buffer can absorb the byte
// HALT  | en dropped; no new pops, waiting for the in-flight byte to land
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PKT_LEN   = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_dout,
  output logic                  fifo_read_enable,
  output logic                  m_valid,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam int               IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [1:0]       DEPTH    = 2'(BUF_DEPTH);

  state_e                  state_q, state_d;
  logic                    inflight_q, inflight_d;
  logic [IDX_W-1:0]        pkt_idx_q, pkt_idx_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]              occ, occ_after;
  logic                    xfer;
  logic [DATA_W-1:0]       head_data;

  stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_dout),
    .pop       (xfer),
    .head_data (head_data),
    .occupancy (occ)
  );

  always_comb begin
    m_valid   = (occ != 2'd0);
    xfer      = m_valid & m_ready;
    // a beat leaving this cycle frees its slot for the byte we pop now
    occ_after = occ - {1'b0, xfer};
    fifo_read_enable = (state_q == RUN) & ~fifo_empty &
                       ((occ_after + {1'b0, inflight_q}) < DEPTH);
    inflight_d = fifo_read_enable & ~fifo_empty;

    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = HALT;
      HALT: begin
        if (en)               state_d = RUN;
        else if (!inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pkt_idx_d  = pkt_idx_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      pkt_idx_d  = (pkt_idx_q == LAST_IDX) ? '0 : pkt_idx_q + IDX_W'(1);
      beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
    end

    m_data   = head_data;
    m_last   = m_valid & (pkt_idx_q == LAST_IDX);
    busy     = (state_q != IDLE) | m_valid;
    beat_cnt = beat_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      pkt_idx_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      pkt_idx_q  <= pkt_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds two instances
// (PKT_LEN 4 and 1); delivered beats are scored against push order.
module tb_fifo_stream_reader;

  localparam int PL  = 4;
  localparam int PL1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty = 1'b1, fifo_empty1 = 1'b1;
  logic [7:0]  fifo_dout = 8'h00, fifo_dout1 = 8'h00;
  logic        fifo_read_enable, fifo_read_enable1;
  logic        m_valid, m_valid1, m_last, m_last1, busy, busy1;
  logic [7:0]  m_data, m_data1;
  logic [15:0] beat_cnt, beat_cnt1;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(8), .PKT_LEN(PL), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read_enable(fifo_read_enable), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .beat_cnt(beat_cnt)
  );

  fifo_stream_reader #(.DATA_W(8), .PKT_LEN(PL1), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty1), .fifo_dout(fifo_dout1),
    .fifo_read_enable(fifo_read_enable1), .m_valid(m_valid1), .m_data(m_data1),
    .m_last(m_last1), .m_ready(m_ready), .busy(busy1), .beat_cnt(beat_cnt1)
  );

  logic [7:0] fq[$], fq1[$], exp_q[$], exp1_q[$];
  int checks = 0, errors = 0;
  int nbeats = 0, nbeats1 = 0, pops = 0, cycle = 0;
  int first_xfer = -1, last_xfer = -1;
  logic stall_prev = 1'b0, last_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    fq1.push_back(b);
    exp1_q.push_back(b);
  endtask

  // One clock: score outputs at negedge, advance, then update the FIFO models.
  task automatic cyc();
    logic pa, pb;
    logic [8:0] want;
    @(negedge clk);
    pa = rst && fifo_read_enable && !fifo_empty;
    pb = rst && fifo_read_enable1 && !fifo_empty1;
    if (rst) begin
      chk("beat_cnt", beat_cnt, nbeats[15:0]);
      if (stall_prev) begin
        chk("stall_data", m_data, data_prev);
        chk("stall_last", m_last, last_prev);
      end
      if (m_valid && m_ready) begin
        want = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        chk("beat_data", {1'b0, m_data}, want);
        chk("beat_last", m_last, ((nbeats % PL) == PL - 1));
        if (first_xfer < 0) first_xfer = cycle;
        last_xfer = cycle;
        nbeats++;
      end
      if (m_valid1 && m_ready) begin
        want = (exp1_q.size() > 0) ? {1'b0, exp1_q.pop_front()} : 9'h100;
        chk("b_beat_data", {1'b0, m_data1}, want);
        chk("b_beat_last", m_last1, ((nbeats1 % PL1) == PL1 - 1));
        nbeats1++;
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
      if (pa) pops++;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (pa && fq.size() > 0) fifo_dout = fq.pop_front();
    else fifo_dout = 8'($urandom);
    if (pb && fq1.size() > 0) fifo_dout1 = fq1.pop_front();
    else fifo_dout1 = 8'($urandom);
    fifo_empty  = (fq.size() == 0);
    fifo_empty1 = (fq1.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; m_ready = 1'b0;
    fq.delete(); fq1.delete(); exp_q.delete(); exp1_q.delete();
    nbeats = 0; nbeats1 = 0; pops = 0; first_xfer = -1; last_xfer = -1;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic drain(input string tag, input int target);
    for (int i = 0; i < 200 && nbeats < target; i++) cyc();
    chk(tag, nbeats, target);
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_rd_en", fifo_read_enable, 0);

    // back-to-back streaming of a preloaded FIFO
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
    en = 1'b1; m_ready = 1'b1;
    drain("t1_beats", 4);
    cyc();
    chk("t1_span", last_xfer - first_xfer, 3);
    chk("t1_pops", pops, 4);
    chk("t1_beat_cnt", beat_cnt, 4);

    // downstream stall: only two pops may be outstanding
    do_reset();
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
    en = 1'b1; m_ready = 1'b0;
    repeat (10) cyc();
    chk("t2_pops_stalled", pops, 2);
    chk("t2_m_valid", m_valid, 1);
    chk("t2_m_data", m_data, 8'h11);
    m_ready = 1'b1;
    drain("t2_beats", 4);
    chk("t2_pops", pops, 4);

    // empty FIFO then a single late byte
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    repeat (6) cyc();
    chk("t3_no_valid", m_valid, 0);
    chk("t3_no_beats", nbeats, 0);
    chk("t3_busy_run", busy, 1);
    push_a(8'hA5);
    drain("t3_beats", 1);

    // en dropped with a pop in flight
    do_reset();
    for (int i = 0; i < 4; i++) push_a(8'($urandom));
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20 && pops < 1; i++) cyc();
    chk("t4_first_pop", pops, 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_halt_rd_en", fifo_read_enable, 0);
    end
    chk("t4_pops_halted", pops, 2);
    chk("t4_beats_halted", nbeats, 2);
    chk("t4_idle_busy", busy, 0);
    en = 1'b1;
    drain("t4_beats_resumed", 4);

    // randomized traffic with en toggling and random backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 15) != 0);
      if (fq.size() < 4 && $urandom_range(0, 1) == 1) push_a(8'($urandom));
      cyc();
    end
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() > 0 || m_valid); i++) cyc();
    chk("t5_all_delivered", exp_q.size(), 0);
    chk("t5_beat_cnt", beat_cnt, nbeats[15:0]);

    // reset while the buffer holds two bytes
    do_reset();
    push_a(8'h5A); push_a(8'h6B); push_a(8'h7C); push_a(8'h8D);
    en = 1'b1; m_ready = 1'b1;
    drain("t6_pre_beats", 2);
    m_ready = 1'b0;
    repeat (4) cyc();
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_beat_cnt", beat_cnt, 2);
    rst = 1'b0; en = 1'b0;
    fq.delete(); exp_q.delete(); nbeats = 0;
    cyc();
    chk("t6_m_valid", m_valid, 0);
    chk("t6_beat_cnt", beat_cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_m_last", m_last, 0);
    chk("t6_m_data", m_data, 0);
    rst = 1'b1;

    // PKT_LEN=1 instance: every beat is last
    do_reset();
    push_b(8'hC1); push_b(8'hC2); push_b(8'hC3);
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 50 && nbeats1 < 3; i++) cyc();
    chk("t7_beats", nbeats1, 3);
    chk("t7_beat_cnt", beat_cnt1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
